// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the program/data RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_RESP  = 2'd2
    } arbState_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector; on a tie the
// requester that did not win last time is chosen.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic lastGnt,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = REQ_CPU;
        if (req0 && req1) begin
            winner = (lastGnt == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (req1) begin
            winner = REQ_DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port program/data RAM between the CPU MAR/MDR
// path and the debug/loader port. Define MEM_ARB_HALT_EN to add dbg_halt (CPU stall).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
`ifdef MEM_ARB_HALT_EN
    ,
    input  logic              dbg_halt
`endif
);

    arbState_e         stateReg;
    arbState_e         stateNext;
    logic              ownerReg;
    logic              lastGntReg;
    logic [ADDR_W-1:0] ramAddrReg;
    logic [DATA_W-1:0] ramDataReg;
    logic              ramWeReg;
    logic              cpuReqEff;
    logic              pickValid;
    logic              pickWinner;
    logic              loadReq;
    logic [1:0]        gntVec;
    logic [1:0]        rvalidVec;

`ifdef MEM_ARB_HALT_EN
    // Halt only masks new CPU requests; an access already past IDLE finishes.
    assign cpuReqEff = cpu_req & ~dbg_halt;
`else
    assign cpuReqEff = cpu_req;
`endif

    rr_pick2 uPick (
        .req0    (cpuReqEff),
        .req1    (dbg_req),
        .lastGnt (lastGntReg),
        .valid   (pickValid),
        .winner  (pickWinner)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateReg <= ARB_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        loadReq   = 1'b0;
        case (stateReg)
            ARB_IDLE: begin
                if (pickValid) begin
                    loadReq   = 1'b1;
                    stateNext = ARB_GRANT;
                end
            end
            ARB_GRANT: stateNext = ramWeReg ? ARB_IDLE : ARB_RESP;
            ARB_RESP:  stateNext = ARB_IDLE;
            default:   stateNext = ARB_IDLE;
        endcase
    end

    // RAM strobes are registered at selection so they are stable for the whole GRANT cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ramAddrReg <= '0;
            ramDataReg <= '0;
            ramWeReg   <= 1'b0;
            ownerReg   <= REQ_CPU;
            lastGntReg <= REQ_DBG;
        end else if (loadReq) begin
            ownerReg   <= pickWinner;
            lastGntReg <= pickWinner;
            if (pickWinner == REQ_DBG) begin
                ramAddrReg <= dbg_addr;
                ramDataReg <= dbg_wdata;
                ramWeReg   <= dbg_we;
            end else begin
                ramAddrReg <= cpu_addr;
                ramDataReg <= cpu_wdata;
                ramWeReg   <= cpu_we;
            end
        end else if (stateReg == ARB_GRANT) begin
            ramWeReg <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : gReqOut
        assign gntVec[gi]    = (stateReg == ARB_GRANT) && (ownerReg == 1'(gi));
        assign rvalidVec[gi] = (stateReg == ARB_RESP) && (ownerReg == 1'(gi));
    end

    assign cpu_gnt    = gntVec[REQ_CPU];
    assign dbg_gnt    = gntVec[REQ_DBG];
    assign cpu_rvalid = rvalidVec[REQ_CPU];
    assign dbg_rvalid = rvalidVec[REQ_DBG];
    assign rdata      = ram_q;
    assign ram_addr   = ramAddrReg;
    assign ram_data   = ramDataReg;
    assign ram_we     = ramWeReg;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port 512×32 program/data RAM between the CPU datapath (MAR/MDR path) and a debug/loader port. It arbitrates requests, drives the RAM address/data/write-enable from registers, and returns read data with a per-requester valid strobe. It sits between the datapath's MAR/MDR outputs, the loader port, and the `ram` instance.

## Interface
Parameters:
- `ADDR_W`, 9: RAM address width.
- `DATA_W`, 32: word width.

Ports:
- `Clock` in 1: system clock; all logic rising-edge.
- `Reset` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU access request, held until grant.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU address (from MAR).
- `cpu_wdata` in DATA_W: CPU write data (from MDR).
- `cpu_gnt` out 1: one-cycle grant pulse.
- `cpu_rvalid` out 1: one-cycle read-data-valid pulse.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`: same widths and meanings as the CPU port, for the loader port.
- `rdata` out DATA_W: shared read-data return, qualified by either `*_rvalid`.
- `ram_addr` out ADDR_W: registered RAM address.
- `ram_data` out DATA_W: registered RAM write data.
- `ram_we` out 1: registered RAM write enable.
- `ram_q` in DATA_W: RAM read data, valid one cycle after the address cycle.
- `dbg_halt` in 1: present only with `MEM_ARB_HALT_EN`.

## Operation
- States: IDLE, GRANT, RESP.
- **IDLE**
  - Samples `cpu_req` and `dbg_req`.
  - If neither is set, stay in IDLE.
  - If exactly one is set, select it.
  - If both are set, select the requester not granted last (`last_gnt` register; reset value = DBG, so CPU wins the first tie).
  - On selection, register addr/wdata/we into `ram_*`, record the owner, update `last_gnt`, and go to GRANT.
- **GRANT**
  - Assert the owner's `*_gnt`.
  - `ram_addr`/`ram_data`/`ram_we` are valid in this cycle, and the RAM samples at the end of it.
  - Read: go to RESP.
  - Write: go to IDLE, with `ram_we` cleared on exit.
- **RESP**
  - `rdata = ram_q` (combinational pass-through).
  - Assert the owner's `*_rvalid`.
  - Go to IDLE.
- Requesters deassert `req` on the clock edge where they see `gnt`=1. A `req` still high in IDLE is a new request.
- Requests raised while in GRANT/RESP are ignored until IDLE and are not lost, because `req` is held.
- `ram_we` is 1 only in GRANT for a write.
- At most one `*_gnt` and at most one `*_rvalid` are high in any cycle.
- Reset values: state = IDLE, `ram_addr` = 0, `ram_data` = 0, `ram_we` = 0, all `gnt`/`rvalid` = 0, `last_gnt` = DBG, `rdata` = don't-care (outside an `rvalid` pulse).
- Reset mid-operation: next cycle returns to IDLE; `ram_we` = 0; any pending `rvalid` is dropped; requesters must re-issue.
- Address/data pass through unchanged (no width arithmetic); addresses wrap naturally at 2^ADDR_W.

## Timing
- Request sampled in cycle N (IDLE).
- Grant and RAM strobe in N+1.
- Read data and `rvalid` in N+2; IDLE again in N+3.
- Write: IDLE again in N+2.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Under continuous contention, the two requesters strictly alternate.
- Worst-case wait for a requesting port is one other access (≤3 cycles) before its grant cycle, except when halted.

## Configuration
- `MEM_ARB_HALT_EN` defined:
  - Adds the `dbg_halt` input.
  - While `dbg_halt` = 1 in IDLE, `cpu_req` is treated as 0: the CPU stalls and DBG has exclusive access.
  - An in-flight CPU access completes normally.
  - Round-robin resumes when `dbg_halt` drops.
- Undefined: the port is absent; pure two-way round-robin.

## Structure
- Package `mem_arb_pkg`:
  - State enum (`ARB_IDLE`, `ARB_GRANT`, `ARB_RESP`).
  - Requester ID constants (`REQ_CPU` = 0, `REQ_DBG` = 1).
  - Default `ADDR_W`/`DATA_W` localparams.
- One sub-module, `rr_pick2`: combinational 2-way round-robin selector.
  - Inputs: two requests plus `last_gnt`.
  - Outputs: `valid` and `winner`.
- The FSM, the owner register and the RAM output registers live in the top.

## Test plan
- CPU write: `cpu_addr` = 9'h005, `cpu_wdata` = 32'hDEADBEEF, `cpu_we` = 1 → `cpu_gnt` and `ram_we` both in cycle N+1 with `ram_addr` = 005; no `rvalid`.
- CPU read-back of 9'h005 → `cpu_gnt` at N+1; `cpu_rvalid` at N+2 with `rdata` = 32'hDEADBEEF.
- Simultaneous reads after reset (CPU addr 001, DBG addr 002) → CPU granted first and DBG next (DBG `gnt` at N+4); each `rvalid` goes only to its owner with the correct data.
- Both requesters held high for 8 accesses → grants strictly alternate CPU/DBG; never two grants in one cycle.
- `Reset` asserted during GRANT of a read → next cycle `ram_we` = 0, no `rvalid`, state IDLE; the re-issued request completes with normal timing.
- (`MEM_ARB_HALT_EN`) `dbg_halt` = 1 with both requesting → only DBG granted for 4 accesses; CPU granted within 1 cycle of IDLE after halt drops.
